// File: rtl/hazard_pkg.sv
// Shared types and widths for the RV32I pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_e;

    localparam int LU_CNT_W   = 2;
    localparam int PERF_CNT_W = 32;

    // Wait counter must be able to hold the timeout value itself.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Forwarding select for a single EX-stage source operand (MEM result wins over WB).
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_m_i,
    input  logic              mem_read_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_w_i,
    output logic [1:0]        sel_o
);

    fwd_sel_e sel;

    // A load in MEM has no ALU result yet, so it can only be forwarded from WB.
    always_comb begin
        sel = FWD_NONE;
        if (reg_write_m_i && !mem_read_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            sel = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            sel = FWD_W;
        end
    end

    assign sel_o = sel;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: operand forwarding, load-use interlock, branch flush, data-memory wait.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int REG_AW       = 5,
    parameter int LOAD_USE_LAT = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]  rsD,
    input  logic [NUM_SRC*REG_AW-1:0]  rsE,
    input  logic [REG_AW-1:0]          rdE,
    input  logic                       RegWriteE,
    input  logic                       MemReadE,
    input  logic [REG_AW-1:0]          rdM,
    input  logic                       RegWriteM,
    input  logic                       MemReadM,
    input  logic                       MemAccessM,
    input  logic                       mem_ready,
    input  logic [REG_AW-1:0]          rdW,
    input  logic                       RegWriteW,
    input  logic                       PCSrcE,
    output logic [NUM_SRC*2-1:0]       ForwardE,
    output logic                       StallF,
    output logic                       StallD,
    output logic                       StallE,
    output logic                       StallM,
    output logic                       FlushD,
    output logic                       FlushE,
    output logic                       FlushW,
    output logic                       mem_timeout,
    output logic [PERF_CNT_W-1:0]      perf_stall_cnt,
    output logic [PERF_CNT_W-1:0]      perf_flush_cnt,
    output logic [PERF_CNT_W-1:0]      perf_fwd_cnt
);

    localparam int                  WAIT_W   = wait_cnt_w(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]   WAIT_MAX = '1;
    localparam logic [WAIT_W-1:0]   WAIT_TMO = WAIT_W'(MEM_TIMEOUT);
    localparam logic [LU_CNT_W-1:0] LU_LAST  = LU_CNT_W'(LOAD_USE_LAT - 1);

    logic [NUM_SRC*2-1:0] fwd_raw;
    logic                 rs_hit;
    logic                 load_use;

    hz_state_e            state_q, state_d;
    hz_state_e            resume_q, resume_d;
    hz_state_e            eff_state;
    logic [LU_CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 timeout_q;
    logic                 timeout_hit;

    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_match #(
            .REG_AW (REG_AW)
        ) u_fwd_match (
            .rs_i          (rsE[i*REG_AW +: REG_AW]),
            .rd_m_i        (rdM),
            .reg_write_m_i (RegWriteM),
            .mem_read_m_i  (MemReadM),
            .rd_w_i        (rdW),
            .reg_write_w_i (RegWriteW),
            .sel_o         (fwd_raw[i*2 +: 2])
        );
    end

    always_comb begin
        rs_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rsD[i*REG_AW +: REG_AW] == rdE) rs_hit = 1'b1;
        end
    end

    assign load_use = MemReadE && RegWriteE && (rdE != '0) && rs_hit;

    // The cycle mem_ready returns is handled by the state we were waiting on behalf of.
    assign eff_state = (state_q == MEM_WAIT && mem_ready) ? resume_q : state_q;

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        lu_cnt_d    = lu_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_hit = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;

        unique case (eff_state)
            MEM_WAIT: begin
                {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                flush_w = 1'b1;
                if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
                timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_TMO);
            end
            RUN, LOAD_STALL: begin
                state_d = eff_state;
                if (state_q == MEM_WAIT) wait_cnt_d = '0;
                if (MemAccessM && !mem_ready) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w    = 1'b1;
                    state_d    = MEM_WAIT;
                    resume_d   = eff_state;
                    wait_cnt_d = WAIT_W'(1);
                end else if (PCSrcE) begin
                    // The ID instruction is squashed, so any pending load-use is moot.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = RUN;
                end else if (eff_state == LOAD_STALL) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    flush_e  = 1'b1;
                    lu_cnt_d = lu_cnt_q + 1'b1;
                    if (lu_cnt_q == LU_LAST) state_d = RUN;
                end else if (load_use) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    flush_e  = 1'b1;
                    lu_cnt_d = LU_CNT_W'(1);
                    state_d  = (LOAD_USE_LAT > 1) ? LOAD_STALL : RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            resume_q   <= RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_q | timeout_hit;
        end
    end

    // Reset forces every control output low immediately, independent of the clock.
    assign ForwardE    = rst_n ? fwd_raw : '0;
    assign StallF      = rst_n & stall_f;
    assign StallD      = rst_n & stall_d;
    assign StallE      = rst_n & stall_e;
    assign StallM      = rst_n & stall_m;
    assign FlushD      = rst_n & flush_d;
    assign FlushE      = rst_n & flush_e;
    assign FlushW      = rst_n & flush_w;
    assign mem_timeout = rst_n & (timeout_q | timeout_hit);

`ifdef HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_CNT_W-1:0] perf_flush_q, perf_flush_d;
    logic [PERF_CNT_W-1:0] perf_fwd_q, perf_fwd_d;

    // Branch flushes are the only source of FlushD, so it doubles as the flush event.
    always_comb begin
        perf_stall_d = perf_stall_q + PERF_CNT_W'(stall_f);
        perf_flush_d = perf_flush_q + PERF_CNT_W'(flush_d);
        perf_fwd_d   = perf_fwd_q + PERF_CNT_W'((|fwd_raw) && !stall_e);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_fwd_q   <= perf_fwd_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_fwd_cnt   = perf_fwd_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
    assign perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit (LOAD_USE_LAT=2, MEM_TIMEOUT=3).
module tb_hazard_ctrl_unit;

    localparam int NUM_SRC = 2;
    localparam int REG_AW  = 5;

`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    localparam logic [3:0] S_NO  = 4'b0000;
    localparam logic [3:0] S_LU  = 4'b1100;
    localparam logic [3:0] S_MEM = 4'b1111;
    localparam logic [2:0] F_NO  = 3'b000;
    localparam logic [2:0] F_LU  = 3'b010;
    localparam logic [2:0] F_BR  = 3'b110;
    localparam logic [2:0] F_MEM = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] rsD, rsE;
    logic [REG_AW-1:0]         rdE, rdM, rdW;
    logic                      RegWriteE, MemReadE, RegWriteM, MemReadM;
    logic                      MemAccessM, mem_ready, RegWriteW, PCSrcE;
    logic [NUM_SRC*2-1:0]      ForwardE;
    logic                      StallF, StallD, StallE, StallM;
    logic                      FlushD, FlushE, FlushW, mem_timeout;
    logic [31:0]               perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt;

    hazard_ctrl_unit #(
        .NUM_SRC      (NUM_SRC),
        .REG_AW       (REG_AW),
        .LOAD_USE_LAT (2),
        .MEM_TIMEOUT  (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rsD            (rsD),
        .rsE            (rsE),
        .rdE            (rdE),
        .RegWriteE      (RegWriteE),
        .MemReadE       (MemReadE),
        .rdM            (rdM),
        .RegWriteM      (RegWriteM),
        .MemReadM       (MemReadM),
        .MemAccessM     (MemAccessM),
        .mem_ready      (mem_ready),
        .rdW            (rdW),
        .RegWriteW      (RegWriteW),
        .PCSrcE         (PCSrcE),
        .ForwardE       (ForwardE),
        .StallF         (StallF),
        .StallD         (StallD),
        .StallE         (StallE),
        .StallM         (StallM),
        .FlushD         (FlushD),
        .FlushE         (FlushE),
        .FlushW         (FlushW),
        .mem_timeout    (mem_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
    );

    typedef struct {
        logic [3:0] fwd;
        logic [3:0] stall;
        logic [2:0] flush;
        logic       tmo;
        logic       rst;
        int         step;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;
    int   t_stall  = 0;
    int   t_flush  = 0;
    int   t_fwd    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rsD = '0; rsE = '0; rdE = '0; rdM = '0; rdW = '0;
        RegWriteE = 1'b0; MemReadE = 1'b0; RegWriteM = 1'b0; MemReadM = 1'b0;
        MemAccessM = 1'b0; mem_ready = 1'b1; RegWriteW = 1'b0; PCSrcE = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input logic [3:0] fwd, input logic [3:0] stall,
                              input logic [2:0] flush, input logic tmo);
        exp_t e;
        step_no++;
        e.fwd = fwd; e.stall = stall; e.flush = flush; e.tmo = tmo;
        e.rst = rst_n; e.step = step_no;
        exp_q.push_back(e);
    endtask

    task automatic load_use_on(input logic [REG_AW-1:0] rd, input logic [NUM_SRC*REG_AW-1:0] rs);
        MemReadE = 1'b1; RegWriteE = 1'b1; rdE = rd; rsD = rs;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val($sformatf("s%0d ForwardE", e.step), 32'(ForwardE), 32'(e.fwd));
            check_val($sformatf("s%0d StallFDEM", e.step), 32'({StallF, StallD, StallE, StallM}), 32'(e.stall));
            check_val($sformatf("s%0d FlushDEW", e.step), 32'({FlushD, FlushE, FlushW}), 32'(e.flush));
            check_val($sformatf("s%0d mem_timeout", e.step), 32'(mem_timeout), 32'(e.tmo));
            if (!e.rst) begin
                t_stall = 0; t_flush = 0; t_fwd = 0;
            end
            check_val($sformatf("s%0d perf_stall", e.step), perf_stall_cnt, PERF_ON ? t_stall : 0);
            check_val($sformatf("s%0d perf_flush", e.step), perf_flush_cnt, PERF_ON ? t_flush : 0);
            check_val($sformatf("s%0d perf_fwd", e.step), perf_fwd_cnt, PERF_ON ? t_fwd : 0);
            if (e.stall[3]) t_stall++;
            if (e.flush[2]) t_flush++;
            if ((e.fwd != 4'b0000) && !e.stall[1]) t_fwd++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset: hazards present on the inputs but every output held low
        next(); MemAccessM = 1'b1; mem_ready = 1'b0; rdM = 5'd5; RegWriteM = 1'b1; rsE = {5'd5, 5'd5};
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); rst_n = 1'b1;
        expect_out(4'b0000, S_NO, F_NO, 1'b0);

        // Forwarding priority and x0 handling
        next(); rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1; rsE = {5'd5, 5'd5};
        expect_out(4'b1010, S_NO, F_NO, 1'b0);
        next(); rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd3; RegWriteW = 1'b1; rsE = {5'd5, 5'd3};
        expect_out(4'b1001, S_NO, F_NO, 1'b0);
        next(); rdM = 5'd0; RegWriteM = 1'b1; rdW = 5'd0; RegWriteW = 1'b1; rsE = {5'd0, 5'd0};
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); rdM = 5'd5; RegWriteM = 1'b1; MemReadM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1; rsE = {5'd5, 5'd6};
        expect_out(4'b0100, S_NO, F_NO, 1'b0);
        next(); rdM = 5'd9; rdW = 5'd9; rsE = {5'd9, 5'd9};
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        for (int k = 1; k < 30; k += 7) begin
            next(); rdM = 5'(k); RegWriteM = 1'b1; rdW = 5'(k + 1); RegWriteW = 1'b1;
            rsE = {5'(k), 5'(k + 1)};
            expect_out(4'b1001, S_NO, F_NO, 1'b0);
        end

        // Load-use on rsD[1]: two bubbles, then the consumer picks the value up from WB
        next(); load_use_on(5'd7, {5'd7, 5'd1});
        expect_out(4'b0000, S_LU, F_LU, 1'b0);
        next(); MemReadM = 1'b1; RegWriteM = 1'b1; rdM = 5'd7; rsD = {5'd7, 5'd1};
        expect_out(4'b0000, S_LU, F_LU, 1'b0);
        next(); rdW = 5'd7; RegWriteW = 1'b1; rsE = {5'd7, 5'd1};
        expect_out(4'b0100, S_NO, F_NO, 1'b0);
        next(); load_use_on(5'd0, {5'd0, 5'd0});
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); load_use_on(5'd12, {5'd3, 5'd12});
        expect_out(4'b0000, S_LU, F_LU, 1'b0);
        next();
        expect_out(4'b0000, S_LU, F_LU, 1'b0);
        next();
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); RegWriteE = 1'b1; rdE = 5'd4; rsD = {5'd4, 5'd4};
        expect_out(4'b0000, S_NO, F_NO, 1'b0);

        // Branch taken with a concurrent load-use: flush only, stay in RUN
        next(); load_use_on(5'd7, {5'd2, 5'd7}); PCSrcE = 1'b1;
        expect_out(4'b0000, S_NO, F_BR, 1'b0);
        next();
        expect_out(4'b0000, S_NO, F_NO, 1'b0);

        // Memory wait of 4 cycles; forwarding stays live while stalled
        next(); MemAccessM = 1'b1; mem_ready = 1'b0;
        expect_out(4'b0000, S_MEM, F_MEM, 1'b0);
        next(); MemAccessM = 1'b1; mem_ready = 1'b0; rdM = 5'd5; RegWriteM = 1'b1; rsE = {5'd5, 5'd0};
        expect_out(4'b1000, S_MEM, F_MEM, 1'b0);
        next(); MemAccessM = 1'b1; mem_ready = 1'b0;
        expect_out(4'b0000, S_MEM, F_MEM, 1'b0);
        next(); MemAccessM = 1'b1; mem_ready = 1'b0;
        expect_out(4'b0000, S_MEM, F_MEM, 1'b1);
        next(); MemAccessM = 1'b1; mem_ready = 1'b1;
        expect_out(4'b0000, S_NO, F_NO, 1'b1);
        next();
        expect_out(4'b0000, S_NO, F_NO, 1'b1);
        next(); rst_n = 1'b0;
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); rst_n = 1'b1;
        expect_out(4'b0000, S_NO, F_NO, 1'b0);

        // Branch held across a memory wait is applied on release
        for (int k = 0; k < 2; k++) begin
            next(); MemAccessM = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
            expect_out(4'b0000, S_MEM, F_MEM, 1'b0);
        end
        next(); MemAccessM = 1'b1; mem_ready = 1'b1; PCSrcE = 1'b1;
        expect_out(4'b0000, S_NO, F_BR, 1'b0);
        next();
        expect_out(4'b0000, S_NO, F_NO, 1'b0);

        // Memory wait in the middle of a load-use stall: bubble count resumes afterwards
        next(); load_use_on(5'd7, {5'd7, 5'd0});
        expect_out(4'b0000, S_LU, F_LU, 1'b0);
        for (int k = 0; k < 2; k++) begin
            next(); MemAccessM = 1'b1; mem_ready = 1'b0;
            expect_out(4'b0000, S_MEM, F_MEM, 1'b0);
        end
        next(); MemAccessM = 1'b1; mem_ready = 1'b1;
        expect_out(4'b0000, S_LU, F_LU, 1'b0);
        next();
        expect_out(4'b0000, S_NO, F_NO, 1'b0);

        // Timeout: sets on the 4th wait cycle and stays set until reset
        for (int k = 1; k <= 10; k++) begin
            next(); MemAccessM = 1'b1; mem_ready = 1'b0;
            expect_out(4'b0000, S_MEM, F_MEM, (k >= 4));
        end
        next(); MemAccessM = 1'b1; mem_ready = 1'b1;
        expect_out(4'b0000, S_NO, F_NO, 1'b1);
        for (int k = 0; k < 3; k++) begin
            next();
            expect_out(4'b0000, S_NO, F_NO, 1'b1);
        end

        // Reset in the middle of a load-use stall
        next(); rst_n = 1'b0;
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); rst_n = 1'b1;
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); load_use_on(5'd7, {5'd7, 5'd7});
        expect_out(4'b0000, S_LU, F_LU, 1'b0);
        next(); rst_n = 1'b0; load_use_on(5'd7, {5'd7, 5'd7});
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next(); rst_n = 1'b1;
        expect_out(4'b0000, S_NO, F_NO, 1'b0);
        next();
        expect_out(4'b0000, S_NO, F_NO, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
